// File: rtl/decode_stage_seq.sv
// ---------------------------------------------------------------------------
// decode_stage_seq
//
// This is the registered decode stage of the 16-bit core. It sits between the
// IF/ID pipe register and execute. It turns one instruction word into an
// ID/EX bundle: register addresses, the selected immediate, a PC-relative
// target and active-high control strobes.
//
// LM/SM instructions are expanded by a small micro-sequencer. It emits one
// micro-op per register selected in the list. The address offset of each
// micro-op is its emission index k, passed in imm.
//
// Ports
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   in_valid / in_ready   upstream handshake (IF/ID)
//   in_pc, in_ir          PC and instruction word of the offered instruction
//   flush                 discard stage contents, abort any LM/SM expansion
//   out_valid / out_ready downstream handshake (ID/EX)
//   out_pc                PC of the bundle (same PC for every LM/SM micro-op)
//   ra1, ra2, wa          read port 1 / read port 2 / write address
//   imm, pc_imm           selected immediate, out_pc + sign-extended offset
//   alu_op                0=ADD, 1=NAND
//   mex1, mex2            ALU operand A/B select (1 = imm)
//   wccr, wmem, mem_rd    flag write, memory write, memory read
//   wrf, wb_sel           register write, write-back source
//   cond                  write condition for the ADD/NAND family
//   is_beq/is_jal/is_jlr  branch/jump class
//   illegal               opcode not in the ISA
//   mm_last               last micro-op of an LM/SM expansion
//
// Sequencer states
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | accepting instructions; single-op decode or LM/SM start
//   S_MULTI | emitting the remaining LM/SM micro-ops, upstream stalled
// ---------------------------------------------------------------------------
module decode_stage_seq #(
    parameter int DW   = 16,
    parameter int RW   = 3,
    parameter int NREG = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_pc,
    input  logic [DW-1:0] in_ir,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_pc,
    output logic [RW-1:0] ra1,
    output logic [RW-1:0] ra2,
    output logic [RW-1:0] wa,
    output logic [DW-1:0] imm,
    output logic [DW-1:0] pc_imm,
    output logic          alu_op,
    output logic          mex1,
    output logic          mex2,
    output logic          wccr,
    output logic          wmem,
    output logic          mem_rd,
    output logic          wrf,
    output logic [1:0]    wb_sel,
    output logic [1:0]    cond,
    output logic          is_beq,
    output logic          is_jal,
    output logic          is_jlr,
    output logic          illegal,
    output logic          mm_last
);

    // The micro-op counter must be able to hold NREG after the last increment.
    localparam int KW = $clog2(NREG + 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADI  = 4'b0001;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_LHI  = 4'b0011;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_LM   = 4'b0110;
    localparam logic [3:0] OP_SM   = 4'b0111;
    localparam logic [3:0] OP_JAL  = 4'b1000;
    localparam logic [3:0] OP_JLR  = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1100;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_IMM = 2'b10;
    localparam logic [1:0] WB_PC1 = 2'b11;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_MULTI = 1'b1
    } state_t;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc;
        logic [RW-1:0] ra1;
        logic [RW-1:0] ra2;
        logic [RW-1:0] wa;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc_imm;
        logic          alu_op;
        logic          mex1;
        logic          mex2;
        logic          wccr;
        logic          wmem;
        logic          mem_rd;
        logic          wrf;
        logic [1:0]    wb_sel;
        logic [1:0]    cond;
        logic          is_beq;
        logic          is_jal;
        logic          is_jlr;
        logic          illegal;
        logic          mm_last;
    } bundle_t;

    state_t          state_q, state_nx;
    bundle_t         bundle_q, bundle_nx;
    bundle_t         dec;

    // State latched at the start of an LM/SM expansion.
    logic [NREG-1:0] mm_list_q, mm_list_nx;
    logic [RW-1:0]   mm_base_q, mm_base_nx;
    logic [DW-1:0]   mm_pc_q, mm_pc_nx;
    logic [DW-1:0]   mm_pc_imm_q, mm_pc_imm_nx;
    logic            mm_sm_q, mm_sm_nx;
    logic [KW-1:0]   mm_k_q, mm_k_nx;

    logic            adv;
    logic            accept;
    logic [3:0]      op;
    logic            is_mm_op;
    logic [DW-1:0]   s6;
    logic [DW-1:0]   s9;
    logic [NREG-1:0] ir_list;
    logic [NREG-1:0] seq_list;
    logic [NREG-1:0] seq_rest;
    logic            seq_last;
    logic [RW-1:0]   sel_idx;

    // -----------------------------------------------------------------------
    // Handshake and field extraction
    // -----------------------------------------------------------------------
    assign adv      = !bundle_q.valid || out_ready;
    assign in_ready = rst_n && !flush && adv && (state_q == S_IDLE);
    assign accept   = in_valid && in_ready;

    assign op       = in_ir[DW-1:DW-4];
    assign is_mm_op = (op == OP_LM) || (op == OP_SM);
    assign s6       = {{(DW-6){in_ir[5]}}, in_ir[5:0]};
    assign s9       = {{(DW-9){in_ir[8]}}, in_ir[8:0]};
    assign ir_list  = in_ir[NREG-1:0];

    // One priority picker serves both the first micro-op (list from the IR)
    // and the following ones (latched list). In IDLE the latched list is
    // always empty, so the IR list is the only source that matters there.
    assign seq_list = (state_q == S_MULTI) ? mm_list_q : ir_list;
    assign seq_rest = seq_list & (seq_list - NREG'(1));
    assign seq_last = (seq_rest == '0);

    always_comb begin
        sel_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (seq_list[i]) begin
                sel_idx = RW'(i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Single-op decode of the offered instruction
    // -----------------------------------------------------------------------
    always_comb begin
        dec        = '0;
        dec.valid  = 1'b1;
        dec.pc     = in_pc;
        dec.pc_imm = in_pc + ((op == OP_JAL) ? s9 : s6);
        unique case (op)
            OP_ADD, OP_NAND: begin
                dec.ra1    = RW'(in_ir[11:9]);
                dec.ra2    = RW'(in_ir[8:6]);
                dec.wa     = RW'(in_ir[5:3]);
                dec.wrf    = 1'b1;
                dec.wccr   = 1'b1;
                dec.wb_sel = WB_ALU;
                dec.cond   = in_ir[1:0];
                dec.alu_op = (op == OP_NAND);
            end
            OP_ADI: begin
                dec.ra1  = RW'(in_ir[11:9]);
                dec.wa   = RW'(in_ir[8:6]);
                dec.imm  = s6;
                dec.mex2 = 1'b1;
                dec.wrf  = 1'b1;
                dec.wccr = 1'b1;
            end
            OP_LHI: begin
                dec.wa     = RW'(in_ir[11:9]);
                dec.imm    = {in_ir[8:0], {(DW-9){1'b0}}};
                dec.wrf    = 1'b1;
                dec.wb_sel = WB_IMM;
            end
            OP_LW: begin
                dec.wa     = RW'(in_ir[11:9]);
                dec.ra2    = RW'(in_ir[8:6]);
                dec.imm    = s6;
                dec.mex1   = 1'b1;
                dec.mem_rd = 1'b1;
                dec.wrf    = 1'b1;
                dec.wb_sel = WB_MEM;
                dec.wccr   = 1'b1;
            end
            OP_SW: begin
                dec.ra1  = RW'(in_ir[11:9]);
                dec.ra2  = RW'(in_ir[8:6]);
                dec.imm  = s6;
                dec.mex1 = 1'b1;
                dec.wmem = 1'b1;
            end
            OP_BEQ: begin
                dec.ra1    = RW'(in_ir[11:9]);
                dec.ra2    = RW'(in_ir[8:6]);
                dec.imm    = s6;
                dec.is_beq = 1'b1;
            end
            OP_JAL: begin
                dec.wa     = RW'(in_ir[11:9]);
                dec.imm    = s9;
                dec.wrf    = 1'b1;
                dec.wb_sel = WB_PC1;
                dec.is_jal = 1'b1;
            end
            OP_JLR: begin
                dec.wa     = RW'(in_ir[11:9]);
                dec.ra2    = RW'(in_ir[8:6]);
                dec.wrf    = 1'b1;
                dec.wb_sel = WB_PC1;
                dec.is_jlr = 1'b1;
            end
            OP_LM, OP_SM: begin
                // Expanded by the sequencer, never loaded from here.
                dec.illegal = 1'b0;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    // One LM/SM micro-op. The address is base + k, so imm carries k.
    function automatic bundle_t build_uop(
        input logic          sm,
        input logic [RW-1:0] base,
        input logic [RW-1:0] reg_i,
        input logic [KW-1:0] k,
        input logic [DW-1:0] pc,
        input logic [DW-1:0] pc_off,
        input logic          last
    );
        bundle_t b;
        b         = '0;
        b.valid   = 1'b1;
        b.pc      = pc;
        b.pc_imm  = pc_off;
        b.ra1     = base;
        b.imm     = DW'(k);
        b.mex2    = 1'b1;
        b.mm_last = last;
        if (sm) begin
            b.ra2  = reg_i;
            b.wmem = 1'b1;
        end else begin
            b.wa     = reg_i;
            b.mem_rd = 1'b1;
            b.wrf    = 1'b1;
            b.wb_sel = WB_MEM;
        end
        return b;
    endfunction

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx = state_q;
        if (flush) begin
            state_nx = S_IDLE;
        end else if (state_q == S_MULTI) begin
            if (adv && seq_last) begin
                state_nx = S_IDLE;
            end
        end else if (accept && is_mm_op && (ir_list != '0) && !seq_last) begin
            state_nx = S_MULTI;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: outputs (next bundle and sequencer latches)
    // -----------------------------------------------------------------------
    always_comb begin
        bundle_nx    = bundle_q;
        mm_list_nx   = mm_list_q;
        mm_base_nx   = mm_base_q;
        mm_pc_nx     = mm_pc_q;
        mm_pc_imm_nx = mm_pc_imm_q;
        mm_sm_nx     = mm_sm_q;
        mm_k_nx      = mm_k_q;
        if (flush) begin
            bundle_nx.valid   = 1'b0;
            bundle_nx.mm_last = 1'b0;
            mm_list_nx        = '0;
        end else if (adv) begin
            if (state_q == S_MULTI) begin
                bundle_nx  = build_uop(mm_sm_q, mm_base_q, sel_idx, mm_k_q,
                                       mm_pc_q, mm_pc_imm_q, seq_last);
                mm_list_nx = seq_rest;
                mm_k_nx    = mm_k_q + KW'(1);
            end else if (accept && is_mm_op) begin
                if (ir_list == '0) begin
                    // Empty list: the instruction is consumed with no bundle.
                    bundle_nx = '0;
                end else begin
                    bundle_nx    = build_uop(op == OP_SM, RW'(in_ir[11:9]),
                                             sel_idx, '0, in_pc, in_pc + s6,
                                             seq_last);
                    mm_list_nx   = seq_rest;
                    mm_base_nx   = RW'(in_ir[11:9]);
                    mm_pc_nx     = in_pc;
                    mm_pc_imm_nx = in_pc + s6;
                    mm_sm_nx     = (op == OP_SM);
                    mm_k_nx      = KW'(1);
                end
            end else if (accept) begin
                bundle_nx = dec;
            end else begin
                bundle_nx = '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output bundle and sequencer registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bundle_q    <= '0;
            mm_list_q   <= '0;
            mm_base_q   <= '0;
            mm_pc_q     <= '0;
            mm_pc_imm_q <= '0;
            mm_sm_q     <= 1'b0;
            mm_k_q      <= '0;
        end else begin
            bundle_q    <= bundle_nx;
            mm_list_q   <= mm_list_nx;
            mm_base_q   <= mm_base_nx;
            mm_pc_q     <= mm_pc_nx;
            mm_pc_imm_q <= mm_pc_imm_nx;
            mm_sm_q     <= mm_sm_nx;
            mm_k_q      <= mm_k_nx;
        end
    end

    assign out_valid = bundle_q.valid;
    assign out_pc    = bundle_q.pc;
    assign ra1       = bundle_q.ra1;
    assign ra2       = bundle_q.ra2;
    assign wa        = bundle_q.wa;
    assign imm       = bundle_q.imm;
    assign pc_imm    = bundle_q.pc_imm;
    assign alu_op    = bundle_q.alu_op;
    assign mex1      = bundle_q.mex1;
    assign mex2      = bundle_q.mex2;
    assign wccr      = bundle_q.wccr;
    assign wmem      = bundle_q.wmem;
    assign mem_rd    = bundle_q.mem_rd;
    assign wrf       = bundle_q.wrf;
    assign wb_sel    = bundle_q.wb_sel;
    assign cond      = bundle_q.cond;
    assign is_beq    = bundle_q.is_beq;
    assign is_jal    = bundle_q.is_jal;
    assign is_jlr    = bundle_q.is_jlr;
    assign illegal   = bundle_q.illegal;
    assign mm_last   = bundle_q.mm_last;

endmodule

// File: tb/tb_decode_stage_seq.sv
// ---------------------------------------------------------------------------
// tb_decode_stage_seq
//
// Scoreboarded bench for decode_stage_seq. Each accepted instruction is
// expanded by an ISA reference model into the bundles it must produce. Those
// bundles are queued and popped on every out_valid && out_ready transfer.
// A flush or reset discards everything in flight.
// ---------------------------------------------------------------------------
module tb_decode_stage_seq;

    localparam int DW   = 16;
    localparam int RW   = 3;
    localparam int NREG = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_pc;
    logic [DW-1:0] in_ir;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_pc;
    logic [RW-1:0] ra1, ra2, wa;
    logic [DW-1:0] imm, pc_imm;
    logic          alu_op, mex1, mex2, wccr, wmem, mem_rd, wrf;
    logic [1:0]    wb_sel, cond;
    logic          is_beq, is_jal, is_jlr, illegal, mm_last;

    always #5 clk = ~clk;

    decode_stage_seq #(.DW(DW), .RW(RW), .NREG(NREG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_ir     (in_ir),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .ra1       (ra1),
        .ra2       (ra2),
        .wa        (wa),
        .imm       (imm),
        .pc_imm    (pc_imm),
        .alu_op    (alu_op),
        .mex1      (mex1),
        .mex2      (mex2),
        .wccr      (wccr),
        .wmem      (wmem),
        .mem_rd    (mem_rd),
        .wrf       (wrf),
        .wb_sel    (wb_sel),
        .cond      (cond),
        .is_beq    (is_beq),
        .is_jal    (is_jal),
        .is_jlr    (is_jlr),
        .illegal   (illegal),
        .mm_last   (mm_last)
    );

    typedef struct packed {
        logic [15:0] pc;
        logic [2:0]  ra1;
        logic [2:0]  ra2;
        logic [2:0]  wa;
        logic [15:0] imm;
        logic [15:0] pc_imm;
        logic        alu_op;
        logic        mex1;
        logic        mex2;
        logic        wccr;
        logic        wmem;
        logic        mem_rd;
        logic        wrf;
        logic [1:0]  wb_sel;
        logic [1:0]  cond;
        logic        is_beq;
        logic        is_jal;
        logic        is_jlr;
        logic        illegal;
        logic        mm_last;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ready_mode = 0;   // 0 hold, 1 toggle, 2 random
    bit   last_acc;
    bit   last_rdy;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t observed();
        exp_t o;
        o.pc = out_pc;  o.ra1 = ra1;  o.ra2 = ra2;  o.wa = wa;
        o.imm = imm;  o.pc_imm = pc_imm;  o.alu_op = alu_op;
        o.mex1 = mex1;  o.mex2 = mex2;  o.wccr = wccr;  o.wmem = wmem;
        o.mem_rd = mem_rd;  o.wrf = wrf;  o.wb_sel = wb_sel;  o.cond = cond;
        o.is_beq = is_beq;  o.is_jal = is_jal;  o.is_jlr = is_jlr;
        o.illegal = illegal;  o.mm_last = mm_last;
        return o;
    endfunction

    // ISA reference: push every bundle an accepted instruction must produce.
    task automatic push_expected(input logic [15:0] pc, input logic [15:0] ir);
        exp_t        e;
        logic [3:0]  op;
        logic [15:0] s6, s9;
        int          n, k;
        op = ir[15:12];
        s6 = {{10{ir[5]}}, ir[5:0]};
        s9 = {{7{ir[8]}}, ir[8:0]};
        e = '0;
        e.pc = pc;
        e.pc_imm = pc + ((op == 4'b1000) ? s9 : s6);
        case (op)
            4'b0000, 4'b0010: begin
                e.ra1 = ir[11:9]; e.ra2 = ir[8:6]; e.wa = ir[5:3];
                e.wrf = 1; e.wccr = 1; e.cond = ir[1:0];
                e.alu_op = (op == 4'b0010);
            end
            4'b0001: begin
                e.ra1 = ir[11:9]; e.wa = ir[8:6]; e.imm = s6;
                e.mex2 = 1; e.wrf = 1; e.wccr = 1;
            end
            4'b0011: begin
                e.wa = ir[11:9]; e.imm = {ir[8:0], 7'b0};
                e.wrf = 1; e.wb_sel = 2'b10;
            end
            4'b0100: begin
                e.wa = ir[11:9]; e.ra2 = ir[8:6]; e.imm = s6; e.mex1 = 1;
                e.mem_rd = 1; e.wrf = 1; e.wb_sel = 2'b01; e.wccr = 1;
            end
            4'b0101: begin
                e.ra1 = ir[11:9]; e.ra2 = ir[8:6]; e.imm = s6;
                e.mex1 = 1; e.wmem = 1;
            end
            4'b1100: begin
                e.ra1 = ir[11:9]; e.ra2 = ir[8:6]; e.imm = s6; e.is_beq = 1;
            end
            4'b1000: begin
                e.wa = ir[11:9]; e.imm = s9; e.wrf = 1;
                e.wb_sel = 2'b11; e.is_jal = 1;
            end
            4'b1001: begin
                e.wa = ir[11:9]; e.ra2 = ir[8:6]; e.wrf = 1;
                e.wb_sel = 2'b11; e.is_jlr = 1;
            end
            4'b0110, 4'b0111: begin
                n = $countones(ir[7:0]);
                k = 0;
                for (int i = 0; i < 8; i++) begin
                    if (ir[i]) begin
                        exp_t u;
                        u = '0;
                        u.pc = pc; u.pc_imm = pc + s6;
                        u.ra1 = ir[11:9]; u.imm = 16'(k); u.mex2 = 1;
                        if (op == 4'b0111) begin
                            u.ra2 = 3'(i); u.wmem = 1;
                        end else begin
                            u.wa = 3'(i); u.mem_rd = 1; u.wrf = 1;
                            u.wb_sel = 2'b01;
                        end
                        u.mm_last = (k == n - 1);
                        sb_q.push_back(u);
                        k++;
                    end
                end
                return;
            end
            default: e.illegal = 1;
        endcase
        sb_q.push_back(e);
    endtask

    // One cycle: called at a falling edge with inputs already driven.
    task automatic tick();
        exp_t e;
        case (ready_mode)
            1: out_ready = !out_ready;
            2: out_ready = ($urandom_range(0, 3) != 0);
            default: ;
        endcase
        #1;
        last_acc = in_valid && in_ready;
        last_rdy = in_ready;
        if (!rst_n || flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_bundle", 128'(out_valid), 128'(0));
                end else begin
                    e = sb_q.pop_front();
                    chk("bundle", 128'(observed()), 128'(e));
                end
            end
            if (in_valid && in_ready) push_expected(in_pc, in_ir);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] pc, input logic [15:0] ir);
        int i;
        in_valid = 1'b1;
        in_pc    = pc;
        in_ir    = ir;
        for (i = 0; i < 64; i++) begin
            tick();
            if (last_acc) break;
        end
        if (i == 64) chk("accept_timeout", 128'(last_acc), 128'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain(input int mode);
        ready_mode = mode;
        for (int i = 0; i < 200; i++) begin
            if (sb_q.size() == 0 && !out_valid) break;
            tick();
        end
        ready_mode = 0;
        out_ready  = 1'b1;
        chk("drain_left", 128'(sb_q.size()), 128'(0));
    endtask

    logic [15:0] stream_ir [10] = '{16'h147B, 16'h2A72, 16'h3F5A, 16'h4A85,
                                    16'h5C3F, 16'hC2BE, 16'h9680, 16'hA123,
                                    16'hF000, 16'h0299};

    initial begin
        int cnt;
        rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_ir = '0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_pc_imm", 128'(pc_imm), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // ADD with known result and one-cycle latency
        send(16'h0010, 16'h0298);
        #1;
        chk("add_valid", 128'(out_valid), 128'(1));
        chk("add_pc_imm", 128'(pc_imm), 128'(16'h0028));
        drain(0);

        // JAL R5, -2
        send(16'h0040, 16'h8BFE);
        #1;
        chk("jal_imm", 128'(imm), 128'(16'hFFFE));
        chk("jal_pc_imm", 128'(pc_imm), 128'(16'h003E));
        chk("jal_wb_sel", 128'(wb_sel), 128'(2'b11));
        drain(0);

        // LM R0, list 0x91: upstream stalled for two cycles
        send(16'h0050, 16'h6091);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_rdy) break;
            cnt++;
        end
        chk("lm_ready_low", 128'(cnt), 128'(2));
        drain(0);

        // SM R2, full list, with out_ready toggling
        send(16'h0060, 16'h74FF);
        drain(1);

        // LM with empty list, then ADD back to back
        send(16'h0070, 16'h6000);
        #1;
        chk("lm0_valid", 128'(out_valid), 128'(0));
        chk("lm0_ready", 128'(in_ready), 128'(1));
        send(16'h0072, 16'h0298);
        drain(0);

        // Decode-table stream under random backpressure
        ready_mode = 2;
        foreach (stream_ir[i]) send(16'h0100 + 16'(i), stream_ir[i]);
        drain(2);

        // Flush during MULTI
        send(16'h0200, 16'h6EFF);
        tick(); tick();
        flush = 1'b1;
        tick();
        chk("flush_in_ready", 128'(last_rdy), 128'(0));
        flush = 1'b0;
        #1;
        chk("flush_out_valid", 128'(out_valid), 128'(0));
        chk("flush_ready_after", 128'(in_ready), 128'(1));
        send(16'h0210, 16'h5C3F);
        drain(0);

        // Reset during MULTI
        send(16'h0300, 16'h7EFF);
        tick();
        rst_n = 1'b0;
        tick();
        chk("rstm_in_ready", 128'(last_rdy), 128'(0));
        rst_n = 1'b1;
        #1;
        chk("rstm_out_valid", 128'(out_valid), 128'(0));
        chk("rstm_ready_after", 128'(in_ready), 128'(1));
        send(16'h0310, 16'h5A41);
        drain(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
